// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one TX byte port among P_NUM_REQ sources.
// Optional build macro TX_ARB_PRIO0_EN gives requester 0 strict priority over the rotation.
module tx_frame_arbiter #(
  parameter int P_NUM_REQ    = 4,
  parameter int P_GAP_CYCLES = 2
) (
  input  logic                   sys_tx_clk,
  input  logic                   sys_tx_rst,
  input  logic [8*P_NUM_REQ-1:0] req_byte,
  input  logic [P_NUM_REQ-1:0]   req_byte_vld,
  output logic [P_NUM_REQ-1:0]   req_byte_rdy,
  input  logic [P_NUM_REQ-1:0]   req_sof,
  input  logic [P_NUM_REQ-1:0]   req_eof,
  output logic [7:0]             sys_tx_byte,
  output logic                   sys_tx_byte_vld,
  input  logic                   sys_tx_byte_rdy,
  output logic                   sys_tx_sof,
  output logic                   sys_tx_eof,
  output logic [P_NUM_REQ-1:0]   grant,
  output logic                   busy,
  output logic                   arb_err
);

  localparam int IW = $clog2(P_NUM_REQ);
  localparam logic [7:0] GAP_INIT = (P_GAP_CYCLES == 0) ? 8'd0 : 8'(P_GAP_CYCLES - 1);
  localparam logic [P_NUM_REQ-1:0] ONE_HOT0 = {{(P_NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARB_XFER, GAP} state_t;

  state_t               state_q;
  logic [P_NUM_REQ-1:0] grant_q;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        widx_q;
  logic [7:0]           gap_cnt_q;
  logic                 arb_err_q;
  logic                 first_q;

  logic [P_NUM_REQ-1:0] elig;
  logic [P_NUM_REQ-1:0] rr_elig;
  logic                 prio0_win;
  logic                 win_vld_d;
  logic [IW-1:0]        win_idx_d;
  logic [IW-1:0]        rr_ptr_d;
  int                   rr_idx;
  logic                 xfer_st;
  logic                 xfer;

  assign elig = req_byte_vld & req_sof;

`ifdef TX_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign prio0_win = elig[0];
  assign rr_elig   = elig & ~ONE_HOT0;
`else
  assign prio0_win = 1'b0;
  assign rr_elig   = elig;
`endif

  always_comb begin
    win_vld_d = prio0_win;
    win_idx_d = '0;
    rr_idx    = 0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      rr_idx = (int'(rr_ptr_q) + k) % P_NUM_REQ;
      if (!win_vld_d && rr_elig[rr_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = IW'(rr_idx);
      end
    end
  end

  assign rr_ptr_d = (win_idx_d == IW'(P_NUM_REQ - 1)) ? '0 : win_idx_d + 1'b1;

  // Data path is a pure mux of the owner; ready never feeds back into valid.
  assign xfer_st         = (state_q == ARB_XFER);
  assign sys_tx_byte     = xfer_st ? req_byte[8*widx_q +: 8] : 8'h00;
  assign sys_tx_byte_vld = xfer_st & req_byte_vld[widx_q];
  assign sys_tx_sof      = xfer_st & req_sof[widx_q];
  assign sys_tx_eof      = xfer_st & req_eof[widx_q];
  assign xfer            = sys_tx_byte_vld & sys_tx_byte_rdy;

  for (genvar gi = 0; gi < P_NUM_REQ; gi++) begin : g_rdy
    assign req_byte_rdy[gi] = xfer_st & grant_q[gi] & sys_tx_byte_rdy;
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign arb_err = arb_err_q;

  always_ff @(posedge sys_tx_clk) begin
    if (sys_tx_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      widx_q    <= '0;
      gap_cnt_q <= '0;
      arb_err_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|(req_byte_vld & ~req_sof)) arb_err_q <= 1'b1;
          if (win_vld_d) begin
            state_q <= ARB_XFER;
            grant_q <= ONE_HOT0 << win_idx_d;
            widx_q  <= win_idx_d;
            first_q <= 1'b1;
            if (!prio0_win) rr_ptr_q <= rr_ptr_d;
          end
        end
        ARB_XFER: begin
          if (xfer) begin
            first_q <= 1'b0;
            if (sys_tx_sof && !first_q) arb_err_q <= 1'b1;
            if (sys_tx_eof) begin
              grant_q <= '0;
              if (P_GAP_CYCLES == 0) begin
                state_q <= IDLE;
              end else begin
                state_q   <= GAP;
                gap_cnt_q <= GAP_INIT;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == 8'd0) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q - 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Randomised/directed bench for tx_frame_arbiter against a per-frame behavioural model.
module tb_tx_frame_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;

  logic           clk = 1'b0;
  logic           srst;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_byte_vld;
  logic [N-1:0]   req_byte_rdy;
  logic [N-1:0]   req_sof;
  logic [N-1:0]   req_eof;
  logic [7:0]     sys_tx_byte;
  logic           sys_tx_byte_vld;
  logic           sys_tx_byte_rdy;
  logic           sys_tx_sof;
  logic           sys_tx_eof;
  logic [N-1:0]   grant;
  logic           busy;
  logic           arb_err;

  always #5 clk = ~clk;

  tx_frame_arbiter #(.P_NUM_REQ(N), .P_GAP_CYCLES(GAP)) dut (
    .sys_tx_clk      (clk),
    .sys_tx_rst      (srst),
    .req_byte        (req_byte),
    .req_byte_vld    (req_byte_vld),
    .req_byte_rdy    (req_byte_rdy),
    .req_sof         (req_sof),
    .req_eof         (req_eof),
    .sys_tx_byte     (sys_tx_byte),
    .sys_tx_byte_vld (sys_tx_byte_vld),
    .sys_tx_byte_rdy (sys_tx_byte_rdy),
    .sys_tx_sof      (sys_tx_sof),
    .sys_tx_eof      (sys_tx_eof),
    .grant           (grant),
    .busy            (busy),
    .arb_err         (arb_err)
  );

  // Pending bytes per requester, with their sof/eof flags.
  logic [7:0] qd[N][$];
  bit         qs[N][$];
  bit         qe[N][$];
  int         pos[N];

  // Model: current owner, remaining gap cycles, rotation pointer, sticky error.
  int m_owner = -1;
  int m_gap   = 0;
  int m_ptr   = 0;
  bit m_first = 1'b0;
  bit m_err   = 1'b0;

  int checks   = 0;
  int failures = 0;
  int vld_pct  = 100;
  int rdy_mode = 0;
  int pat_idx  = 0;
  int cyc      = 0;
  bit after_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int i, input int len, input int extra_sof);
    for (int b = 0; b < len; b++) begin
      qd[i].push_back(8'($urandom_range(255)));
      qs[i].push_back((b == 0) || (b == extra_sof));
      qe[i].push_back(b == len - 1);
    end
  endtask

  task automatic pop_byte(input int i);
    void'(qd[i].pop_front());
    void'(qs[i].pop_front());
    void'(qe[i].pop_front());
  endtask

  function automatic int pick(input bit [N-1:0] el, input int ptr);
`ifdef TX_ARB_PRIO0_EN
    if (el[0]) return 0;
    el[0] = 1'b0;
`endif
    for (int k = 0; k < N; k++)
      if (el[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic bit model_idle();
    if (m_owner >= 0 || m_gap > 0) return 1'b0;
    for (int i = 0; i < N; i++)
      if (qd[i].size() > 0 && qs[i][0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cycle(input bit rst);
    bit [N-1:0]   dv, ds, de, el;
    logic [7:0]   db [N];
    logic [N-1:0] one, exp_g;
    bit           sr;
    int           w;
    int           o;
    bit           last;
    @(negedge clk);
    cyc++;
    one = 1;
    for (int i = 0; i < N; i++) begin
      if (qd[i].size() > 0) begin
        dv[i] = ($urandom_range(99) < vld_pct);
        db[i] = qd[i][0];
        ds[i] = qs[i][0];
        de[i] = qe[i][0];
      end else begin
        dv[i] = 1'b0;
        db[i] = 8'($urandom_range(255));
        ds[i] = 1'b0;
        de[i] = 1'b0;
      end
      req_byte[8*i +: 8] = db[i];
    end
    req_byte_vld = dv;
    req_sof      = ds;
    req_eof      = de;
    case (rdy_mode)
      1:       sr = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
      2:       sr = 1'($urandom_range(1));
      default: sr = 1'b1;
    endcase
    pat_idx++;
    if (rst) sr = 1'b0;
    sys_tx_byte_rdy = sr;
    srst            = rst;
    #1;
    exp_g = (m_owner >= 0) ? (one << m_owner) : '0;
    chk("grant", 32'(grant), 32'(exp_g));
    chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap > 0)));
    chk("arb_err", 32'(arb_err), 32'(m_err));
    chk("req_rdy", 32'(req_byte_rdy), sr ? 32'(exp_g) : 32'd0);
    if (m_owner >= 0) begin
      o = m_owner;
      chk("out_vld", 32'(sys_tx_byte_vld), 32'(dv[o]));
      if (dv[o]) begin
        chk("out_byte", 32'(sys_tx_byte), 32'(db[o]));
        chk("out_sof", 32'(sys_tx_sof), 32'(ds[o]));
        chk("out_eof", 32'(sys_tx_eof), 32'(de[o]));
      end
    end else begin
      chk("idle_vld", 32'(sys_tx_byte_vld), 32'd0);
    end
    if (after_rst) begin
      chk("rst_byte", 32'(sys_tx_byte), 32'd0);
      chk("rst_sof", 32'(sys_tx_sof), 32'd0);
      chk("rst_eof", 32'(sys_tx_eof), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    after_rst = rst;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        if (pos[i] > 0) begin
          while (qd[i].size() > 0) begin
            last = qe[i][0];
            pop_byte(i);
            if (last) break;
          end
        end
        pos[i] = 0;
      end
      m_owner = -1; m_gap = 0; m_ptr = 0; m_first = 1'b0; m_err = 1'b0;
    end else if (m_owner >= 0) begin
      o = m_owner;
      if (dv[o] && sr) begin
        if (ds[o] && !m_first) m_err = 1'b1;
        m_first = 1'b0;
        pop_byte(o);
        pos[o]++;
        if (de[o]) begin
          pos[o]  = 0;
          m_owner = -1;
          m_gap   = GAP;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (dv[i] && !ds[i]) m_err = 1'b1;
        el[i] = dv[i] && ds[i];
      end
      w = pick(el, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_first = 1'b1;
`ifdef TX_ARB_PRIO0_EN
        if (w != 0) m_ptr = (w + 1) % N;
`else
        m_ptr = (w + 1) % N;
`endif
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!model_idle()) begin
      cycle(1'b0);
      n++;
      if (n > budget) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout observed=%0d cycles required<=%0d", n, budget);
        break;
      end
    end
    cycle(1'b0);
    cycle(1'b0);
  endtask

  initial begin
    srst = 1'b1; req_byte = '0; req_byte_vld = '0; req_sof = '0; req_eof = '0;
    sys_tx_byte_rdy = 1'b0;
    for (int i = 0; i < N; i++) pos[i] = 0;

    // Reset and reset-value checks.
    cycle(1'b1); cycle(1'b1); cycle(1'b0);
    chk("reset_rdy", 32'(req_byte_rdy), 32'd0);
    chk("reset_err", 32'(arb_err), 32'd0);

    // 60-byte frame on requester 2, ready held high.
    push_frame(2, 60, -1);
    drain(200);

    // All four requesters with back-to-back 8-byte frames.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < N; i++) push_frame(i, 8, -1);
    drain(400);

    // Ready toggling 1,0,0,1 on a 10-byte frame.
    rdy_mode = 1; pat_idx = 0;
    push_frame(0, 10, -1);
    drain(200);
    rdy_mode = 0;

    // Single-byte frame 0xA5 on requester 1.
    qd[1].push_back(8'hA5); qs[1].push_back(1'b1); qe[1].push_back(1'b1);
    drain(50);
    chk("single_byte_err", 32'(arb_err), 32'd0);

    // Requester 3 valid without sof in IDLE; requester 0 frame still passes.
    qd[3].push_back(8'h3C); qs[3].push_back(1'b0); qe[3].push_back(1'b0);
    push_frame(0, 6, -1);
    drain(100);
    for (int k = 0; k < 4; k++) cycle(1'b0);
    chk("stall_err_sticky", 32'(arb_err), 32'd1);
    chk("stall_no_grant3", 32'(grant[3]), 32'd0);
    pop_byte(3);
    cycle(1'b0);

    // Reset at byte 5 of a 12-byte frame, then a fresh frame.
    push_frame(2, 12, -1);
    for (int k = 0; k < 40 && pos[2] != 5; k++) cycle(1'b0);
    chk("mid_frame_pos", 32'(pos[2]), 32'd5);
    cycle(1'b1);
    push_frame(1, 4, -1);
    drain(100);

    // Randomised frames, valid gaps and ready backpressure.
    vld_pct = 75; rdy_mode = 2;
    for (int f = 0; f < 30; f++)
      push_frame($urandom_range(N - 1), $urandom_range(1, 20), -1);
    drain(5000);

    // Second sof inside a frame raises the sticky error.
    vld_pct = 100; rdy_mode = 0;
    push_frame(1, 6, 3);
    drain(100);
    chk("mid_sof_err", 32'(arb_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
